// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode-to-PC-sequencer handshake bundle (exc_count under PC_SEQ_EXC_COUNT_EN)
interface pc_sequencer_if;
    logic       start_instr;
    logic [2:0] op_kind;
    logic       branch_taken;
    logic       exc_opcode;
    logic       exc_overflow;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       vec_rd;
    logic [7:0] vec_addr;
    logic [1:0] exc_cause;
    logic       busy;
    logic       done;
`ifdef PC_SEQ_EXC_COUNT_EN
    logic [15:0] exc_count;
`endif

    modport master (
        output start_instr, op_kind, branch_taken, exc_opcode, exc_overflow,
`ifdef PC_SEQ_EXC_COUNT_EN
        input  exc_count,
`endif
        input  pc_source, pc_write, epc_write, vec_rd, vec_addr, exc_cause, busy, done
    );

    modport slave (
        input  start_instr, op_kind, branch_taken, exc_opcode, exc_overflow,
`ifdef PC_SEQ_EXC_COUNT_EN
        output exc_count,
`endif
        output pc_source, pc_write, epc_write, vec_rd, vec_addr, exc_cause, busy, done
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC update / exception vector sequencer; optional exc_count via PC_SEQ_EXC_COUNT_EN
module pc_sequencer #(
    parameter int unsigned VEC_WAIT = 2,
    parameter logic [7:0]  OPC_VEC  = 8'd253,
    parameter logic [7:0]  OVF_VEC  = 8'd254
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UPDATE, EXC_SAVE, EXC_WAIT, EXC_LOAD} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(VEC_WAIT);

    state_t     state_q, state_d;
    logic [2:0] pc_source_q, pc_source_d;
    logic       pc_write_q, pc_write_d;
    logic       epc_write_q, epc_write_d;
    logic       vec_rd_q, vec_rd_d;
    logic [7:0] vec_addr_q, vec_addr_d;
    logic [1:0] exc_cause_q, exc_cause_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;
    logic       opc_exc;
    logic       exc_enter;
`ifdef PC_SEQ_EXC_COUNT_EN
    logic [15:0] exc_count_q, exc_count_d;
`endif

    // Reserved op_kind encodings are reported as invalid opcodes.
    assign opc_exc = bus.exc_opcode || (bus.op_kind > 3'd4);

    always_comb begin
        state_d     = state_q;
        pc_source_d = 3'b000;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        vec_rd_d    = 1'b0;
        done_d      = 1'b0;
        vec_addr_d  = vec_addr_q;
        exc_cause_d = exc_cause_q;
        cnt_d       = cnt_q;
        exc_enter   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_instr) begin
                    if (opc_exc || bus.exc_overflow) begin
                        state_d     = EXC_SAVE;
                        exc_enter   = 1'b1;
                        epc_write_d = 1'b1;
                        vec_rd_d    = 1'b1;
                        cnt_d       = WAIT_INIT;
                        exc_cause_d = opc_exc ? 2'b01 : 2'b10;
                        vec_addr_d  = opc_exc ? OPC_VEC : OVF_VEC;
                    end else begin
                        // Outputs are latched here, so later input changes cannot alter the update.
                        state_d     = UPDATE;
                        pc_source_d = bus.op_kind;
                        pc_write_d  = !((bus.op_kind == 3'b001) && !bus.branch_taken);
                        done_d      = 1'b1;
                    end
                end
            end
            UPDATE:   state_d = IDLE;
            EXC_SAVE: begin
                state_d  = EXC_WAIT;
                vec_rd_d = 1'b1;
            end
            EXC_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d     = EXC_LOAD;
                    pc_source_d = 3'b101;
                    pc_write_d  = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    vec_rd_d = 1'b1;
                end
            end
            EXC_LOAD: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

`ifdef PC_SEQ_EXC_COUNT_EN
    always_comb begin
        exc_count_d = exc_count_q;
        if (exc_enter && (exc_count_q != 16'hFFFF))
            exc_count_d = exc_count_q + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_source_q <= 3'b000;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            vec_rd_q    <= 1'b0;
            vec_addr_q  <= 8'd0;
            exc_cause_q <= 2'b00;
            done_q      <= 1'b0;
            cnt_q       <= 4'd0;
`ifdef PC_SEQ_EXC_COUNT_EN
            exc_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_source_q <= pc_source_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            vec_rd_q    <= vec_rd_d;
            vec_addr_q  <= vec_addr_d;
            exc_cause_q <= exc_cause_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
`ifdef PC_SEQ_EXC_COUNT_EN
            exc_count_q <= exc_count_d;
`endif
        end
    end

    assign bus.pc_source = pc_source_q;
    assign bus.pc_write  = pc_write_q;
    assign bus.epc_write = epc_write_q;
    assign bus.vec_rd    = vec_rd_q;
    assign bus.vec_addr  = vec_addr_q;
    assign bus.exc_cause = exc_cause_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef PC_SEQ_EXC_COUNT_EN
    assign bus.exc_count = exc_count_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int VW = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.start_instr  = 1'b0;
        bus.op_kind      = 3'b000;
        bus.branch_taken = 1'b0;
        bus.exc_opcode   = 1'b0;
        bus.exc_overflow = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_src"},   32'(bus.pc_source), 0);
        chk({tag, "_pcw"},   32'(bus.pc_write),  0);
        chk({tag, "_epcw"},  32'(bus.epc_write), 0);
        chk({tag, "_vrd"},   32'(bus.vec_rd),    0);
        chk({tag, "_vaddr"}, 32'(bus.vec_addr),  0);
        chk({tag, "_cause"}, 32'(bus.exc_cause), 0);
        chk({tag, "_busy"},  32'(bus.busy),      0);
        chk({tag, "_done"},  32'(bus.done),      0);
    endtask

    // Inputs must already request the exception; checks SAVE, WAIT, LOAD and return to IDLE.
    task automatic run_exc(input string tag, input logic [1:0] cause, input logic [7:0] addr);
        step();
        chk({tag, "_save_epcw"}, 32'(bus.epc_write), 1);
        chk({tag, "_save_vrd"},  32'(bus.vec_rd),    1);
        chk({tag, "_save_addr"}, 32'(bus.vec_addr),  32'(addr));
        chk({tag, "_save_cause"},32'(bus.exc_cause), 32'(cause));
        chk({tag, "_save_pcw"},  32'(bus.pc_write),  0);
        // start held high while busy must be ignored
        bus.op_kind = 3'b010; bus.exc_opcode = 1'b0; bus.exc_overflow = 1'b0;
        for (int i = 0; i < VW; i++) begin
            step();
            chk({tag, "_wait_vrd"},  32'(bus.vec_rd),    1);
            chk({tag, "_wait_addr"}, 32'(bus.vec_addr),  32'(addr));
            chk({tag, "_wait_pcw"},  32'(bus.pc_write),  0);
            chk({tag, "_wait_epcw"}, 32'(bus.epc_write), 0);
            chk({tag, "_wait_done"}, 32'(bus.done),      0);
        end
        bus.start_instr = 1'b0;
        step();
        chk({tag, "_load_src"},  32'(bus.pc_source), 5);
        chk({tag, "_load_pcw"},  32'(bus.pc_write),  1);
        chk({tag, "_load_done"}, 32'(bus.done),      1);
        chk({tag, "_load_vrd"},  32'(bus.vec_rd),    0);
        step();
        chk({tag, "_end_busy"},  32'(bus.busy),      0);
        chk({tag, "_end_done"},  32'(bus.done),      0);
        chk({tag, "_end_cause"}, 32'(bus.exc_cause), 32'(cause));
    endtask

    typedef struct { logic [2:0] op; logic taken; logic [2:0] src; logic pcw; } upd_vec_t;
    upd_vec_t uv[5] = '{
        '{3'b010, 1'b0, 3'b010, 1'b1},
        '{3'b001, 1'b0, 3'b001, 1'b0},
        '{3'b001, 1'b1, 3'b001, 1'b1},
        '{3'b011, 1'b0, 3'b011, 1'b1},
        '{3'b100, 1'b1, 3'b100, 1'b1}
    };

    initial begin
        idle_in();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk_reset_vals("rst");

        foreach (uv[k]) begin
            bus.start_instr = 1'b1; bus.op_kind = uv[k].op; bus.branch_taken = uv[k].taken;
            step();
            bus.start_instr = 1'b0; bus.op_kind = 3'b011; bus.branch_taken = ~uv[k].taken;
            chk($sformatf("upd%0d_src", k),  32'(bus.pc_source), 32'(uv[k].src));
            chk($sformatf("upd%0d_pcw", k),  32'(bus.pc_write),  32'(uv[k].pcw));
            chk($sformatf("upd%0d_done", k), 32'(bus.done),      1);
            chk($sformatf("upd%0d_busy", k), 32'(bus.busy),      1);
            chk($sformatf("upd%0d_epcw", k), 32'(bus.epc_write), 0);
            step();
            chk($sformatf("upd%0d_idle_busy", k), 32'(bus.busy),     0);
            chk($sformatf("upd%0d_idle_pcw", k),  32'(bus.pc_write), 0);
            chk($sformatf("upd%0d_idle_done", k), 32'(bus.done),     0);
        end

        bus.start_instr = 1'b1; bus.op_kind = 3'b000; bus.exc_overflow = 1'b1;
        run_exc("ovf", 2'b10, 8'd254);
        idle_in();

        bus.start_instr = 1'b1; bus.exc_opcode = 1'b1; bus.exc_overflow = 1'b1;
        run_exc("both", 2'b01, 8'd253);
        idle_in();

        bus.start_instr = 1'b1; bus.op_kind = 3'b110;
        run_exc("rsvd", 2'b01, 8'd253);
        idle_in();

        // Abort in second wait cycle.
        bus.start_instr = 1'b1; bus.exc_overflow = 1'b1;
        step();
        idle_in();
        step(); step();
        chk("abort_in_wait_vrd", 32'(bus.vec_rd), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("abort");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_after_pcw",  32'(bus.pc_write),  0);
            chk("abort_after_epcw", 32'(bus.epc_write), 0);
        end

        // Reset wins over start in the same cycle.
        bus.start_instr = 1'b1; bus.op_kind = 3'b010; reset = 1'b1;
        step();
        reset = 1'b0; bus.start_instr = 1'b0;
        chk("rst_prio_busy", 32'(bus.busy), 0);
        chk("rst_prio_done", 32'(bus.done), 0);
        chk("rst_prio_pcw",  32'(bus.pc_write), 0);

`ifdef PC_SEQ_EXC_COUNT_EN
        chk("cnt_zero", 32'(bus.exc_count), 0);
        for (int i = 0; i < 3; i++) begin
            bus.start_instr = 1'b1; bus.exc_overflow = 1'b1;
            run_exc("cnt_exc", 2'b10, 8'd254);
            idle_in();
        end
        chk("cnt_three", 32'(bus.exc_count), 3);
        force dut.exc_count_q = 16'hFFFF;
        step();
        release dut.exc_count_q;
        bus.start_instr = 1'b1; bus.exc_opcode = 1'b1;
        run_exc("cnt_sat_exc", 2'b01, 8'd253);
        idle_in();
        chk("cnt_sat", 32'(bus.exc_count), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter VEC_WAIT, default 2: handler-vector memory read latency in cycles; legal range 1..15.
REQ-002 Parameter OPC_VEC, default 8'd253: memory byte address of the invalid-opcode handler vector.
REQ-003 Parameter OVF_VEC, default 8'd254: memory byte address of the overflow handler vector.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_instr  input  1  decode complete; PC update requested this cycle.
REQ-007 op_kind  input  3  000 sequential, 001 branch, 010 jump, 011 jr, 100 rfe; 101-111 reserved.
REQ-008 branch_taken  input  1  branch condition result; sampled with start_instr.
REQ-009 exc_opcode  input  1  invalid-opcode exception; sampled with start_instr.
REQ-010 exc_overflow  input  1  ALU overflow exception; sampled with start_instr.
REQ-011 pc_source  output  3  PC mux select: 000 ALU, 001 ALUOut, 010 shifted target, 011 JR, 100 EPC, 101 handler address.
REQ-012 pc_write  output  1  PC register write enable.
REQ-013 epc_write  output  1  EPC register write enable.
REQ-014 vec_rd  output  1  handler-vector memory read request.
REQ-015 vec_addr  output  8  handler-vector address.
REQ-016 exc_cause  output  2  00 none, 01 opcode, 10 overflow; held until the next exception.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on the cycle the PC is finally written or the update is skipped.

Function
REQ-019 States SHALL be IDLE, UPDATE, EXC_SAVE, EXC_WAIT and EXC_LOAD; all outputs are registered or decoded from state only.
REQ-020 In IDLE with start_instr=1, the next state SHALL be: EXC_SAVE with cause 01 if exc_opcode=1 or op_kind is reserved; else EXC_SAVE with cause 10 if exc_overflow=1; else UPDATE.
REQ-021 Opcode exceptions SHALL take priority over overflow when both are asserted.
REQ-022 op_kind and branch_taken SHALL be captured at acceptance; later input changes SHALL NOT affect the update.
REQ-023 UPDATE SHALL last one cycle, driving pc_source from captured op_kind (000->000, 001->001, 010->010, 011->011, 100->100) and asserting done.
REQ-024 In UPDATE, pc_write SHALL be 1 except for a branch with branch_taken=0, where it SHALL be 0.
REQ-025 EXC_SAVE SHALL last one cycle with epc_write=1, vec_rd=1, vec_addr=OPC_VEC or OVF_VEC according to cause, and a 4-bit wait counter loaded with VEC_WAIT.
REQ-026 EXC_WAIT SHALL hold vec_rd=1 and vec_addr, decrement the counter each cycle, and last exactly VEC_WAIT cycles before entering EXC_LOAD.
REQ-027 EXC_LOAD SHALL last one cycle with pc_source=101, pc_write=1 and done=1, then return to IDLE.
REQ-028 In IDLE, pc_source SHALL be 000 and pc_write, epc_write, vec_rd and done SHALL be 0.
REQ-029 start_instr SHALL be ignored while busy=1; no request is queued.
REQ-030 Latency from acceptance at cycle N SHALL be: normal PC write at N+1; exception EPC write at N+1 and handler PC write at N+2+VEC_WAIT.
REQ-031 pc_write and epc_write SHALL never be asserted in the same cycle.

Reset
REQ-032 When reset=1 at a rising edge, the block SHALL enter IDLE with pc_source=000, pc_write=0, epc_write=0, vec_rd=0, vec_addr=0, exc_cause=00, busy=0, done=0 and the wait counter at 0.
REQ-033 Reset asserted in any state, including mid-EXC_WAIT, SHALL abort the sequence with no further pc_write or epc_write.
REQ-034 Reset SHALL take priority over start_instr in the same cycle.

Configuration
REQ-035 With macro PC_SEQ_EXC_COUNT_EN defined, the block SHALL add output exc_count (16 bits), reset to 0, incremented on each EXC_SAVE entry and saturating at 16'hFFFF.
REQ-036 Without PC_SEQ_EXC_COUNT_EN, exc_count SHALL NOT exist and behaviour SHALL otherwise be identical.

Verification
REQ-037 Jump: start_instr=1, op_kind=010 at cycle 5 -> cycle 6 pc_source=010, pc_write=1, done=1; cycle 7 busy=0.
REQ-038 Branch not taken: op_kind=001, branch_taken=0 -> UPDATE cycle with pc_source=001, pc_write=0, done=1.
REQ-039 Overflow, VEC_WAIT=2: exc_overflow=1 at cycle 10 -> cycle 11 epc_write=1, vec_addr=254; vec_rd=1 at cycles 11-13; cycle 14 pc_source=101, pc_write=1; exc_cause=10.
REQ-040 Both exceptions, plus reserved op_kind=110 -> exc_cause=01, vec_addr=253 in each case.
REQ-041 Reset at the second EXC_WAIT cycle -> next cycle IDLE with all outputs at reset values and no pc_write thereafter; start_instr during busy produces no extra done.
REQ-042 With PC_SEQ_EXC_COUNT_EN defined, 3 exceptions -> exc_count=3; force count to 16'hFFFF, then one more exception -> stays 16'hFFFF.
